// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the 8-bit CPU control path: opcodes,
// FSM encodings, microstep numbering and the datapath control word layout.
package arch_defs_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int DATA_WIDTH   = 8;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_NOP    = 4'h0;
    localparam opcode_t OP_LDA    = 4'h1;
    localparam opcode_t OP_ADD    = 4'h2;
    localparam opcode_t OP_SUB    = 4'h3;
    localparam opcode_t OP_STA    = 4'h4;
    localparam opcode_t OP_LDI    = 4'h5;
    localparam opcode_t OP_JMP    = 4'h6;
    localparam opcode_t OP_JC     = 4'h7;
    localparam opcode_t OP_JZ     = 4'h8;
    localparam opcode_t OP_AND    = 4'h9;
    localparam opcode_t OP_OR     = 4'hA;
    localparam opcode_t OP_LDB    = 4'hB;
    localparam opcode_t OP_UNUSED = 4'hC;
    localparam opcode_t OP_OUTM   = 4'hD;
    localparam opcode_t OP_OUTA   = 4'hE;
    localparam opcode_t OP_HLT    = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t S_RESET    = 3'd0;
    localparam fsm_state_t S_FETCH_0  = 3'd1;
    localparam fsm_state_t S_FETCH_1  = 3'd2;
    localparam fsm_state_t S_DECODE_0 = 3'd3;
    localparam fsm_state_t S_DECODE_1 = 3'd4;
    localparam fsm_state_t S_EXECUTE  = 3'd5;
    localparam fsm_state_t S_WAIT     = 3'd6;
    localparam fsm_state_t S_HALT     = 3'd7;

    typedef logic [3:0] microstep_t;

    localparam microstep_t MS0 = 4'd0;
    localparam microstep_t MS1 = 4'd1;
    localparam microstep_t MS2 = 4'd2;
    localparam microstep_t MS7 = 4'd7;

    typedef struct packed {
        logic    oe_pc;
        logic    oe_ram;
        logic    oe_ir;
        logic    oe_a;
        logic    oe_alu;
        logic    load_mar;
        logic    load_ir;
        logic    load_a;
        logic    load_b;
        logic    load_ram;
        logic    load_pc;
        logic    load_o;
        logic    load_flags;
        logic    pc_enable;
        alu_op_t alu_op;
        logic    check_zero;
        logic    check_carry;
        logic    halt;
        logic    last_step;
    } control_word_t;

    localparam control_word_t CW_ZERO = 20'h00000;

    function automatic alu_op_t alu_sel(input opcode_t op);
        alu_op_t sel;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    // A jump only loads the PC when every flag it checks is set.
    function automatic control_word_t gate_load_pc(input control_word_t cw,
                                                   input logic flag_zero,
                                                   input logic flag_carry);
        control_word_t gated;
        gated         = cw;
        gated.load_pc = cw.load_pc & (~cw.check_zero | flag_zero) & (~cw.check_carry | flag_carry);
        return gated;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode lookup: (opcode, microstep) -> raw control word.
// Unlisted steps and unused opcodes yield a zero word (unused opcode acts as NOP).
module microcode_rom
    import arch_defs_pkg::*;
(
    input  opcode_t       opcode,
    input  microstep_t    microstep,
    output control_word_t control_word
);

    control_word_t cw_s;

    // Microcode table decode
    always_comb begin
        cw_s = CW_ZERO;
        case (opcode)
            OP_LDA, OP_LDB, OP_OUTM: begin
                case (microstep)
                    MS0: begin
                        cw_s.oe_ir    = 1'b1;
                        cw_s.load_mar = 1'b1;
                    end
                    MS1: begin
                        cw_s.oe_ram    = 1'b1;
                        cw_s.load_a    = (opcode == OP_LDA);
                        cw_s.load_b    = (opcode == OP_LDB);
                        cw_s.load_o    = (opcode == OP_OUTM);
                        cw_s.last_step = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                case (microstep)
                    MS0: begin
                        cw_s.oe_ir    = 1'b1;
                        cw_s.load_mar = 1'b1;
                    end
                    MS1: begin
                        cw_s.oe_ram = 1'b1;
                        cw_s.load_b = 1'b1;
                    end
                    MS2: begin
                        cw_s.oe_alu     = 1'b1;
                        cw_s.load_a     = 1'b1;
                        cw_s.load_flags = 1'b1;
                        cw_s.alu_op     = alu_sel(opcode);
                        cw_s.last_step  = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            OP_STA: begin
                case (microstep)
                    MS0: begin
                        cw_s.oe_ir    = 1'b1;
                        cw_s.load_mar = 1'b1;
                    end
                    MS1: begin
                        cw_s.oe_a      = 1'b1;
                        cw_s.load_ram  = 1'b1;
                        cw_s.last_step = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            OP_LDI, OP_JMP, OP_JC, OP_JZ: begin
                case (microstep)
                    MS0: begin
                        cw_s.oe_ir       = 1'b1;
                        cw_s.load_a      = (opcode == OP_LDI);
                        cw_s.load_pc     = (opcode != OP_LDI);
                        cw_s.check_carry = (opcode == OP_JC);
                        cw_s.check_zero  = (opcode == OP_JZ);
                        cw_s.last_step   = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            OP_OUTA: begin
                case (microstep)
                    MS0: begin
                        cw_s.oe_a      = 1'b1;
                        cw_s.load_o    = 1'b1;
                        cw_s.last_step = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            OP_HLT: begin
                case (microstep)
                    MS0: begin
                        cw_s.halt      = 1'b1;
                        cw_s.last_step = 1'b1;
                    end
                    default: cw_s = CW_ZERO;
                endcase
            end
            default: begin
                case (microstep)
                    MS0:     cw_s.last_step = 1'b1;
                    default: cw_s = CW_ZERO;
                endcase
            end
        endcase
    end

    assign control_word = cw_s;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode/execute FSM with registered control word,
// conditional-jump gating, RAM-write settle cycle, sticky halt and a step watchdog.
module control_unit
    import arch_defs_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  opcode_t       opcode,
    input  logic          flag_zero,
    input  logic          flag_carry,
    output control_word_t control_word,
    output fsm_state_t    state,
    output microstep_t    microstep
);

    fsm_state_t    state_r;
    fsm_state_t    state_next_s;
    microstep_t    microstep_r;
    microstep_t    ms_next_s;
    opcode_t       opcode_r;
    control_word_t control_word_r;
    control_word_t cw_next_s;
    control_word_t rom_word_s;
    logic          reset_done_r;
    logic          watchdog_s;

    // The ROM is addressed with the step that will be live after the next edge.
    microcode_rom u_microcode_rom (
        .opcode       (opcode_r),
        .microstep    (ms_next_s),
        .control_word (rom_word_s)
    );

    // Next-state and next-microstep sequencing
    always_comb begin
        state_next_s = state_r;
        ms_next_s    = MS0;
        watchdog_s   = 1'b0;
        case (state_r)
            S_RESET: begin
                if (reset_done_r) begin
                    state_next_s = S_FETCH_0;
                end else begin
                    state_next_s = S_RESET;
                end
            end
            S_FETCH_0:  state_next_s = S_FETCH_1;
            S_FETCH_1:  state_next_s = S_DECODE_0;
            S_DECODE_0: state_next_s = S_DECODE_1;
            S_DECODE_1: state_next_s = S_EXECUTE;
            S_EXECUTE: begin
                if (control_word_r.last_step) begin
                    if (control_word_r.halt) begin
                        state_next_s = S_HALT;
                    end else if (control_word_r.load_ram) begin
                        state_next_s = S_WAIT;
                    end else begin
                        state_next_s = S_FETCH_0;
                    end
                end else if (microstep_r == MS7) begin
                    state_next_s = S_FETCH_0;
                    watchdog_s   = 1'b1;
                end else begin
                    state_next_s = S_EXECUTE;
                    ms_next_s    = microstep_r + 4'd1;
                end
            end
            S_WAIT:  state_next_s = S_FETCH_0;
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_RESET;
        endcase
    end

    // Control word for the cycle after the next edge
    always_comb begin
        cw_next_s = CW_ZERO;
        case (state_next_s)
            S_FETCH_0: begin
                if (watchdog_s) begin
                    cw_next_s = CW_ZERO;
                end else begin
                    cw_next_s.oe_pc    = 1'b1;
                    cw_next_s.load_mar = 1'b1;
                end
            end
            S_FETCH_1: begin
                cw_next_s.oe_ram    = 1'b1;
                cw_next_s.load_ir   = 1'b1;
                cw_next_s.pc_enable = 1'b1;
            end
            S_EXECUTE: cw_next_s = gate_load_pc(rom_word_s, flag_zero, flag_carry);
            S_HALT:    cw_next_s.halt = 1'b1;
            default:   cw_next_s = CW_ZERO;
        endcase
    end

    // State, microstep, control word and opcode latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_RESET;
            microstep_r    <= MS0;
            control_word_r <= CW_ZERO;
            opcode_r       <= OP_NOP;
            reset_done_r   <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            microstep_r    <= ms_next_s;
            control_word_r <= cw_next_s;
            reset_done_r   <= 1'b1;
            if (state_r == S_DECODE_0) begin
                opcode_r <= opcode;
            end
        end
    end

    assign control_word = control_word_r;
    assign state        = state_r;
    assign microstep    = microstep_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expected control words are
// hand-assembled hex constants from the control word bit layout.
module tb_control_unit;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_F0    = 3'd1;
    localparam logic [2:0] ST_F1    = 3'd2;
    localparam logic [2:0] ST_D0    = 3'd3;
    localparam logic [2:0] ST_D1    = 3'd4;
    localparam logic [2:0] ST_EX    = 3'd5;
    localparam logic [2:0] ST_WAIT  = 3'd6;
    localparam logic [2:0] ST_HALT  = 3'd7;

    localparam logic [3:0] C_NOP = 4'h0, C_ADD = 4'h2, C_SUB = 4'h3, C_STA = 4'h4,
                           C_LDI = 4'h5, C_JC = 4'h7, C_JZ = 4'h8, C_UNUSED = 4'hC,
                           C_HLT = 4'hF;

    // bit19 oe_pc .. bit0 last_step
    localparam logic [19:0] W_ZERO    = 20'h00000;
    localparam logic [19:0] W_F0      = 20'h84000;
    localparam logic [19:0] W_F1      = 20'h42040;
    localparam logic [19:0] W_LDI     = 20'h21001;
    localparam logic [19:0] W_MAR     = 20'h24000;
    localparam logic [19:0] W_ALU1    = 20'h40800;
    localparam logic [19:0] W_ADD2    = 20'h09081;
    localparam logic [19:0] W_SUB2    = 20'h09091;
    localparam logic [19:0] W_STA1    = 20'h10401;
    localparam logic [19:0] W_JZ_NO   = 20'h20009;
    localparam logic [19:0] W_JZ_YES  = 20'h20209;
    localparam logic [19:0] W_JC_NO   = 20'h20005;
    localparam logic [19:0] W_JC_YES  = 20'h20205;
    localparam logic [19:0] W_NOP     = 20'h00001;
    localparam logic [19:0] W_HLT_EX  = 20'h00003;
    localparam logic [19:0] W_HALTED  = 20'h00002;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic        flag_zero;
    logic        flag_carry;
    logic [19:0] cw;
    logic [2:0]  st;
    logic [3:0]  ms;

    int tests_run;
    int tests_failed;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .control_word (cw),
        .state        (st),
        .microstep    (ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [2:0] exp_st, input logic [19:0] exp_cw);
        check_eq({tag, "_state"}, {29'h0, st}, {29'h0, exp_st});
        check_eq({tag, "_cw"}, {12'h0, cw}, {12'h0, exp_cw});
    endtask

    // Entered with F0 visible; leaves with the first execute cycle visible.
    // The opcode input is scrambled after decode to prove it was latched.
    task automatic fetch_decode(input logic [3:0] op, input string tag);
        opcode = op;
        expect_cycle({tag, "_f0"}, ST_F0, W_F0);
        @(negedge clk);
        expect_cycle({tag, "_f1"}, ST_F1, W_F1);
        @(negedge clk);
        expect_cycle({tag, "_d0"}, ST_D0, W_ZERO);
        @(negedge clk);
        expect_cycle({tag, "_d1"}, ST_D1, W_ZERO);
        check_eq({tag, "_d1_ms"}, {28'h0, ms}, 32'h0);
        opcode = ~op;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        opcode       = C_LDI;
        flag_zero    = 1'b0;
        flag_carry   = 1'b0;

        repeat (2) @(negedge clk);
        expect_cycle("rst_hold", ST_RESET, W_ZERO);
        check_eq("rst_hold_ms", {28'h0, ms}, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        expect_cycle("rst_rel1", ST_RESET, W_ZERO);
        @(negedge clk);

        fetch_decode(C_LDI, "ldi");
        expect_cycle("ldi_ex", ST_EX, W_LDI);
        check_eq("ldi_ex_ms", {28'h0, ms}, 32'h0);
        @(negedge clk);

        fetch_decode(C_ADD, "add");
        expect_cycle("add_ms0", ST_EX, W_MAR);
        @(negedge clk);
        expect_cycle("add_ms1", ST_EX, W_ALU1);
        check_eq("add_ms1_ms", {28'h0, ms}, 32'h1);
        @(negedge clk);
        expect_cycle("add_ms2", ST_EX, W_ADD2);
        check_eq("add_ms2_ms", {28'h0, ms}, 32'h2);
        @(negedge clk);

        fetch_decode(C_SUB, "sub");
        repeat (2) @(negedge clk);
        expect_cycle("sub_ms2", ST_EX, W_SUB2);
        @(negedge clk);

        fetch_decode(C_JZ, "jz0");
        expect_cycle("jz0_ex", ST_EX, W_JZ_NO);
        @(negedge clk);
        flag_zero = 1'b1;
        fetch_decode(C_JZ, "jz1");
        expect_cycle("jz1_ex", ST_EX, W_JZ_YES);
        @(negedge clk);
        flag_zero = 1'b0;
        fetch_decode(C_JC, "jc0");
        expect_cycle("jc0_ex", ST_EX, W_JC_NO);
        @(negedge clk);
        flag_carry = 1'b1;
        fetch_decode(C_JC, "jc1");
        expect_cycle("jc1_ex", ST_EX, W_JC_YES);
        @(negedge clk);
        flag_carry = 1'b0;

        fetch_decode(C_STA, "sta");
        expect_cycle("sta_ms0", ST_EX, W_MAR);
        @(negedge clk);
        expect_cycle("sta_ms1", ST_EX, W_STA1);
        @(negedge clk);
        expect_cycle("sta_wait", ST_WAIT, W_ZERO);
        @(negedge clk);

        fetch_decode(C_UNUSED, "unused");
        expect_cycle("unused_ex", ST_EX, W_NOP);
        @(negedge clk);

        fetch_decode(C_ADD, "addrst");
        @(negedge clk);
        expect_cycle("addrst_ms1", ST_EX, W_ALU1);
        reset = 1'b1;
        #1;
        expect_cycle("addrst_async", ST_RESET, W_ZERO);
        check_eq("addrst_async_ms", {28'h0, ms}, 32'h0);
        @(negedge clk);
        expect_cycle("addrst_held", ST_RESET, W_ZERO);
        reset = 1'b0;
        @(negedge clk);
        expect_cycle("addrst_rel1", ST_RESET, W_ZERO);
        @(negedge clk);

        fetch_decode(C_HLT, "hlt");
        expect_cycle("hlt_ex", ST_EX, W_HLT_EX);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            expect_cycle("hlt_sticky", ST_HALT, W_HALTED);
            opcode = 4'(i);
        end
        reset = 1'b1;
        #1;
        expect_cycle("hlt_rst", ST_RESET, W_ZERO);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_cycle("hlt_rel1", ST_RESET, W_ZERO);
        @(negedge clk);

        fetch_decode(C_LDI, "restart");
        expect_cycle("restart_ex", ST_EX, W_LDI);
        @(negedge clk);
        expect_cycle("restart_f0", ST_F0, W_F0);

        opcode = C_NOP;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
